// File: rtl/multi_oneshot.sv
// multi_oneshot: NUM_CH independent edge-triggered one-shots with a shared,
// programmable pulse length.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   level_in   per-channel level inputs
//   ch_en      per-channel enable (0 aborts an active pulse)
//   edge_sel   per-channel mode [2i+1:2i]: 00 rise, 01 fall, 10 both, 11 none
//   pulse_len  pulse length in cycles (0 behaves as 1)
//   retrig     1: an edge during a pulse reloads it; 0: the edge is dropped
//   ovr_clr    clears all overrun flags (a same-cycle set wins)
//   pulse_out  registered per-channel pulses
//   busy       same as pulse_out, kept for status-register mapping
//   overrun    sticky per-channel "edge dropped" flags
//   any_pulse  registered OR of pulse_out, aligned with pulse_out
//
// Optional build macro MULTI_ONESHOT_SYNC_EN: inserts a 2-flop synchroniser
// per channel ahead of edge detection (adds 2 cycles of latency).
//
// Per-channel state is implicit in the down-counter:
//   state | meaning
//   IDLE  | cnt == 0, waiting for a selected edge
//   PULSE | cnt != 0, pulse_out high, counting down to 0
module multi_oneshot #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     level_in,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [2*NUM_CH-1:0]   edge_sel,
  input  logic [LEN_W-1:0]      pulse_len,
  input  logic                  retrig,
  input  logic                  ovr_clr,
  output logic [NUM_CH-1:0]     pulse_out,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     overrun,
  output logic                  any_pulse
);

  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] prev;
  logic [LEN_W-1:0]  cnt     [NUM_CH];
  logic [LEN_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] pulse_nxt;
  logic [NUM_CH-1:0] ovr_set;
  logic [LEN_W-1:0]  load_val;

`ifdef MULTI_ONESHOT_SYNC_EN
  logic [NUM_CH-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= level_in;
      sync2 <= sync1;
    end
  end

  assign lvl = sync2;
`else
  assign lvl = level_in;
`endif

  assign load_val = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

  always_comb begin
    pulse_nxt = '0;
    ovr_set   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic rise, fall, ev;
      rise = lvl[i] & ~prev[i];
      fall = ~lvl[i] & prev[i];
      case (edge_sel[2*i +: 2])
        2'b00:   ev = rise;
        2'b01:   ev = fall;
        2'b10:   ev = rise | fall;
        default: ev = 1'b0;
      endcase

      cnt_nxt[i] = cnt[i];
      if (!ch_en[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == '0) begin
        if (ev) cnt_nxt[i] = load_val;
      end else if (ev && retrig) begin
        cnt_nxt[i] = load_val;
      end else begin
        // Decrement only from a non-zero count, so no wrap is possible.
        cnt_nxt[i] = cnt[i] - LEN_W'(1);
        ovr_set[i] = ev;
      end
      pulse_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      pulse_out <= '0;
      overrun   <= '0;
      any_pulse <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      // prev tracks regardless of ch_en so re-enabling on a held level is silent.
      prev      <= lvl;
      pulse_out <= pulse_nxt;
      any_pulse <= |pulse_nxt;
      overrun   <= (overrun & ~{NUM_CH{ovr_clr}}) | ovr_set;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign busy = pulse_out;

endmodule

// File: tb/tb_multi_oneshot.sv
module tb_multi_oneshot;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] level_in, ch_en, pulse_out, busy, overrun;
  logic [2*NUM_CH-1:0] edge_sel;
  logic [LEN_W-1:0]  pulse_len;
  logic              retrig, ovr_clr, any_pulse;

  multi_oneshot #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .level_in(level_in), .ch_en(ch_en),
    .edge_sel(edge_sel), .pulse_len(pulse_len), .retrig(retrig),
    .ovr_clr(ovr_clr), .pulse_out(pulse_out), .busy(busy),
    .overrun(overrun), .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] o;
    logic              a;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int hi [NUM_CH];

  // Reference model state
  int                m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_prev = '0;
  logic [NUM_CH-1:0] m_ovr  = '0;
  logic [NUM_CH-1:0] m_s1   = '0;
  logic [NUM_CH-1:0] m_s2   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_push();
    exp_t x;
    logic [NUM_CH-1:0] lv;
    int L;
    logic r, f, e;
`ifdef MULTI_ONESHOT_SYNC_EN
    lv = m_s2;
`else
    lv = level_in;
`endif
    L = (pulse_len == 0) ? 1 : int'(pulse_len);
    if (reset) begin
      m_prev = '0; m_ovr = '0; m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    end else begin
      if (ovr_clr) m_ovr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r = lv[i] && !m_prev[i];
        f = !lv[i] && m_prev[i];
        case ({edge_sel[2*i+1], edge_sel[2*i]})
          2'b00: e = r;
          2'b01: e = f;
          2'b10: e = r || f;
          default: e = 1'b0;
        endcase
        if (!ch_en[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == 0) begin
          if (e) m_cnt[i] = L;
        end else if (e && retrig) m_cnt[i] = L;
        else begin
          m_cnt[i] = m_cnt[i] - 1;
          if (e) m_ovr[i] = 1'b1;
        end
      end
      m_prev = lv;
      m_s2 = m_s1;
      m_s1 = level_in;
    end
    for (int i = 0; i < NUM_CH; i++) x.p[i] = (m_cnt[i] != 0);
    x.o = m_ovr;
    x.a = |x.p;
    q.push_back(x);
  endtask

  task automatic step();
    exp_t x;
    model_push();
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("pulse_out", 32'(pulse_out), 32'(x.p));
    chk("busy", 32'(busy), 32'(x.p));
    chk("overrun", 32'(overrun), 32'(x.o));
    chk("any_pulse", 32'(any_pulse), 32'(x.a));
    for (int i = 0; i < NUM_CH; i++) if (pulse_out[i] === 1'b1) hi[i]++;
  endtask

  task automatic clr_hi();
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
  endtask

  initial begin
    reset = 1'b1; level_in = 4'b0001; ch_en = '1; edge_sel = '0;
    pulse_len = 8'd1; retrig = 1'b0; ovr_clr = 1'b0;
    clr_hi();
    step(); step();
    chk("reset_pulse", 32'(pulse_out), 32'd0);
    chk("reset_ovr", 32'(overrun), 32'd0);

    // Level already high after reset: exactly one 1-cycle pulse.
    reset = 1'b0; clr_hi();
    step();
    chk("first_edge", 32'(pulse_out[0]), 32'd1);
    repeat (5) step();
    chk("held_level_len", 32'(hi[0]), 32'd1);

    // pulse_len=5 rising on ch1
    pulse_len = 8'd5; clr_hi(); level_in[1] = 1'b1;
    repeat (8) step();
    chk("len5", 32'(hi[1]), 32'd5);
    level_in[1] = 1'b0; step();

    // both-edge mode on ch2, pulse_len=3
    edge_sel[5:4] = 2'b10; pulse_len = 8'd3; clr_hi();
    level_in[2] = 1'b1; repeat (10) step();
    chk("both_rise", 32'(hi[2]), 32'd3);
    level_in[2] = 1'b0; repeat (10) step();
    chk("both_total", 32'(hi[2]), 32'd6);

    // retrig=1: edges 2 cycles apart with pulse_len=4 -> 6 contiguous cycles
    level_in[0] = 1'b0; step(); step();
    pulse_len = 8'd4; retrig = 1'b1; clr_hi();
    level_in[0] = 1'b1; step();
    level_in[0] = 1'b0; step();
    level_in[0] = 1'b1; repeat (8) step();
    chk("retrig_len", 32'(hi[0]), 32'd6);
    chk("retrig_no_ovr", 32'(overrun[0]), 32'd0);

    // retrig=0: second edge dropped, overrun set
    level_in[0] = 1'b0; step(); step();
    retrig = 1'b0; clr_hi();
    level_in[0] = 1'b1; step();
    level_in[0] = 1'b0; step();
    level_in[0] = 1'b1; repeat (8) step();
    chk("noretrig_len", 32'(hi[0]), 32'd4);
    chk("noretrig_ovr", 32'(overrun[0]), 32'd1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun[0]), 32'd0);

    // pulse_len=0 behaves as 1
    pulse_len = 8'd0; level_in[0] = 1'b0; step(); clr_hi();
    level_in[0] = 1'b1; step();
    level_in[0] = 1'b0; step();
    level_in[0] = 1'b1; repeat (3) step();
    chk("len0", 32'(hi[0]), 32'd2);

    // ch_en dropped mid-pulse, re-enable on held level
    pulse_len = 8'd10; level_in[3] = 1'b1; step(); step(); step();
    ch_en[3] = 1'b0; step();
    chk("disable_abort", 32'(pulse_out[3]), 32'd0);
    step();
    ch_en[3] = 1'b1; clr_hi(); repeat (5) step();
    chk("reenable_silent", 32'(hi[3]), 32'd0);

    // reset during a 10-cycle pulse
    level_in[3] = 1'b0; step();
    level_in[3] = 1'b1; step(); step(); step();
    reset = 1'b1; step();
    chk("reset_abort", 32'(pulse_out), 32'd0);
    chk("reset_any", 32'(any_pulse), 32'd0);
    level_in = '0; step();
    reset = 1'b0; clr_hi(); repeat (12) step();
    chk("no_residual", 32'(hi[3]), 32'd0);

    // overrun set and clear in the same cycle: set wins
    pulse_len = 8'd4; level_in[1] = 1'b1; step();
    level_in[1] = 1'b0; step();
    level_in[1] = 1'b1; ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("set_wins", 32'(overrun[1]), 32'd1);
    repeat (5) step();

    // randomised traffic checked against the model
    for (int n = 0; n < 300; n++) begin
      level_in  = NUM_CH'($urandom);
      if ($urandom_range(0, 9) == 0) ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 19) == 0) edge_sel = (2*NUM_CH)'($urandom);
      pulse_len = LEN_W'($urandom_range(0, 6));
      retrig    = 1'($urandom);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
